fir_mac_seq: RTL and testbench



---
 rtl/fir_mac_seq_if.sv | 35 +++
 rtl/fir_mac_seq.sv | 134 +++++++++++++
 tb/tb_fir_mac_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fir_mac_seq_if.sv
// ============================================================================
// fir_mac_seq_if : sample/coefficient/result bundle for fir_mac_seq  (rev 1.0)
// ============================================================================
`default_nettype none

interface fir_mac_seq_if #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int NTAPS  = 1021,
  parameter int NUM_CH = 2
);
  localparam int AW = $clog2(NTAPS);

  logic                   sequencing;
  logic [NUM_CH*DW-1:0]   smpl_in;
  logic [CW-1:0]          coeff;
  logic [AW-1:0]          coeff_addr;
  logic [NUM_CH*DW-1:0]   smpl_out;
  logic                   out_vld;
  logic                   busy;
  logic                   err_short;
  logic                   err_ovr;

  modport master (
    output sequencing, smpl_in, coeff,
    input  coeff_addr, smpl_out, out_vld, busy, err_short, err_ovr
  );

  modport slave (
    input  sequencing, smpl_in, coeff,
    output coeff_addr, smpl_out, out_vld, busy, err_short, err_ovr
  );
endinterface

`default_nettype wire

// File: rtl/fir_mac_seq.sv
// ============================================================================
// fir_mac_seq : multi-channel sequenced FIR MAC with saturation   (rev 1.0)
// ============================================================================
`default_nettype none

module fir_mac_seq #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int NTAPS  = 1021,
  parameter int NUM_CH = 2
) (
  input  logic           clk,
  input  logic           rst,
  fir_mac_seq_if.slave   bus
);
  localparam int AW   = $clog2(NTAPS);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + $clog2(NTAPS);

  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [AW-1:0] K_PEN  = AW'(NTAPS - 2);

  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]          OMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          OMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                 state;
  logic [AW-1:0]          k;
  logic [AW-1:0]          addr;
  logic signed [ACCW-1:0] acc     [NUM_CH];
  logic signed [ACCW-1:0] acc_nxt [NUM_CH];
  logic [NUM_CH*DW-1:0]   sat_all;
  logic [NUM_CH*DW-1:0]   out_q;
  logic                   vld_q;
  logic                   busy_q;
  logic                   short_q;
  logic                   ovr_q;

  // The result register loads from acc_nxt so the last tap lands in the same edge.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic signed [PW-1:0]   prod;
      logic signed [ACCW-1:0] shifted;

      assign prod       = $signed(bus.coeff) * $signed(bus.smpl_in[c*DW +: DW]);
      assign acc_nxt[c] = acc[c] + {{(ACCW-PW){prod[PW-1]}}, prod};
      assign shifted    = acc_nxt[c] >>> (CW - 1);
      assign sat_all[c*DW +: DW] = (shifted > SMAX) ? OMAX :
                                   (shifted < SMIN) ? OMIN : shifted[DW-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      addr    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      vld_q   <= 1'b0;
      short_q <= 1'b0;
      ovr_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          addr   <= '0;
          busy_q <= 1'b0;
          if (bus.sequencing) begin
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
            k      <= '0;
            // ROM[0] is already being fetched; prefetch the next tap.
            addr   <= AW'(1);
            busy_q <= 1'b1;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.sequencing) begin
            for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
            if (k == K_LAST) begin
              addr  <= '0;
              out_q <= sat_all;
              vld_q <= 1'b1;
              state <= S_DONE;
            end else begin
              k    <= k + AW'(1);
              addr <= (k == K_PEN) ? '0 : k + AW'(2);
            end
          end else begin
            addr    <= '0;
            short_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          if (bus.sequencing) begin
            ovr_q <= 1'b1;
            state <= S_HOLD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!bus.sequencing) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.coeff_addr = addr;
  assign bus.smpl_out   = out_q;
  assign bus.out_vld    = vld_q;
  assign bus.busy       = busy_q;
  assign bus.err_short  = short_q;
  assign bus.err_ovr    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
// ============================================================================
// tb_fir_mac_seq : scoreboard bench for fir_mac_seq with NTAPS=4  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_fir_mac_seq;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_seq_if #(.DW(DW), .CW(CW), .NTAPS(NT), .NUM_CH(NC)) bus ();

  fir_mac_seq #(.DW(DW), .CW(CW), .NTAPS(NT), .NUM_CH(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [CW-1:0] rom [NT];
  always @(posedge clk) bus.coeff <= rom[bus.coeff_addr];

  int total = 0;
  int bad   = 0;
  logic [31:0] sbq [$];
  logic [31:0] last_out = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int s);
    longint a;
    a = 0;
    for (int k = 0; k < NT; k++) a += longint'(rom[k]) * longint'(s);
    a = a >>> (CW - 1);
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    return a[15:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_vld) begin
      if (sbq.size() == 0) chk("unexpected_vld", 1, 0);
      else                 chk("smpl_out", bus.smpl_out, sbq.pop_front());
    end
  end

  task automatic drive(input bit seq, input int s0, input int s1);
    @(negedge clk);
    bus.sequencing = seq;
    bus.smpl_in    = {s1[15:0], s0[15:0]};
  endtask

  task automatic set_rom(input int v);
    for (int k = 0; k < NT; k++) rom[k] = v[CW-1:0];
  endtask

  // hi = cycles sequencing stays high starting from the IDLE cycle.
  task automatic run_frame(input int hi, input int s0, input int s1);
    logic [31:0] e;
    e = {model(s1), model(s0)};
    sbq.push_back(e);
    for (int t = 0; t < hi; t++) begin
      drive(1'b1, s0, s1);
      if (t <= NT) chk("coeff_addr", bus.coeff_addr, (t == 0 || t == NT) ? 0 : t);
      if (t <= NT + 2) begin
        chk("out_vld", bus.out_vld, t == NT + 1);
        chk("err_ovr", bus.err_ovr, t == NT + 2);
      end
    end
    drive(1'b0, s0, s1);
    if (hi == NT + 1) begin
      chk("out_vld_done", bus.out_vld, 1);
      chk("busy_done", bus.busy, 1);
    end
    last_out = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sequencing = 1'b0;
    bus.smpl_in    = '0;
    set_rom(16'h4000);
    repeat (3) @(negedge clk);
    chk("rst_addr", bus.coeff_addr, 0);
    chk("rst_out", bus.smpl_out, 0);
    chk("rst_flags", {bus.out_vld, bus.busy, bus.err_short, bus.err_ovr}, 0);
    rst = 1'b0;
    drive(1'b0, 0, 0);

    // basic gain-of-two frame
    run_frame(NT + 1, 1000, -1000);
    chk("t2_value", last_out, {16'hF830, 16'd2000});

    // saturation on both rails
    set_rom(16'h7FFF);
    run_frame(NT + 1, 32'h7FFF, 32'hFFFF8000);
    chk("t3_value", last_out, {16'h8000, 16'h7FFF});

    // short frame: drops on ACCUM k=2 cycle
    set_rom(16'h4000);
    drive(1'b1, 5, 5);
    drive(1'b1, 5, 5);
    drive(1'b1, 5, 5);
    drive(1'b0, 5, 5);
    chk("t4_short_early", bus.err_short, 0);
    drive(1'b0, 5, 5);
    chk("t4_err_short", bus.err_short, 1);
    chk("t4_addr", bus.coeff_addr, 0);
    chk("t4_out_kept", bus.smpl_out, last_out);
    chk("t4_busy", bus.busy, 0);
    drive(1'b0, 5, 5);
    chk("t4_short_once", bus.err_short, 0);

    // overrun: sequencing held 8 cycles, then a fresh frame
    run_frame(8, 700, -50);
    chk("t5_hold_exit_busy", bus.busy, 0);
    run_frame(NT + 1, -123, 4567);

    // back-to-back frames with one low cycle between
    run_frame(NT + 1, 100, 7);
    chk("t6_first", last_out[15:0], 16'd200);
    run_frame(NT + 1, -300, 9);
    chk("t6_second", last_out[15:0], 16'hFDA8);

    // mid-frame reset
    drive(1'b1, 11, 22);
    drive(1'b1, 11, 22);
    drive(1'b1, 11, 22);
    @(negedge clk);
    rst = 1'b1;
    bus.sequencing = 1'b0;
    @(negedge clk);
    chk("t1_addr", bus.coeff_addr, 0);
    chk("t1_out", bus.smpl_out, 0);
    chk("t1_flags", {bus.out_vld, bus.busy, bus.err_short, bus.err_ovr}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 0, 0);
    chk("t1_no_short", bus.err_short, 0);
    run_frame(NT + 1, 2500, -2500);

    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
